branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequences the control-flow redirect that follows a resolved taken branch or jump in the EX stage. It takes the branch_control decision (o_DoBranch) and the computed target, and drives a valid/ack redirect handshake to the fetch unit. It also squashes the younger IF/ID instructions and stalls EX until the redirect has been accepted and drained. It also flags misaligned targets and keeps a redirect counter for performance monitoring.

## Interface
- XLEN, 32, width of PC/target
- CNT_W, 16, width of redirect counter

- i_CLK  in  1  clock, all state updates on rising edge
- i_RSTn  in  1  asynchronous, active-low reset
- i_Valid  in  1  EX holds a valid instruction this cycle
- i_DoBranch  in  1  conditional branch taken (from branch_control)
- i_Jump  in  1  unconditional jump (JAL/JALR) in EX
- i_Target  in  XLEN  resolved target address
- i_Stall  in  1  EX held by a downstream stall; no new trigger accepted
- i_Redirect_ack  in  1  fetch unit accepts redirect this cycle
- o_Redirect_req  out  1  redirect request to fetch
- o_PC_target  out  XLEN  target presented with o_Redirect_req
- o_Flush  out  1  squash IF/ID contents
- o_Busy  out  1  redirect in progress; EX must hold
- o_Misaligned  out  1  one-cycle pulse: target not 4-byte aligned
- o_Redirects  out  CNT_W  count of completed redirects

## Operation
- Trigger: i_Valid & (i_DoBranch | i_Jump) & ~i_Stall, sampled only in IDLE. A trigger in any other state is ignored, with nothing captured and no counter change.
- FSM states: IDLE, REDIRECT, DRAIN.
- IDLE, trigger, i_Target[1:0]==2'b00:
  - Register the target into o_PC_target.
  - Next state is REDIRECT.
- IDLE, trigger, i_Target[1:0]!=2'b00:
  - o_Misaligned=1 for exactly the next cycle.
  - State stays IDLE; no request, no flush, o_PC_target unchanged.
- REDIRECT:
  - Outputs: o_Redirect_req=1, o_Flush=1, o_Busy=1.
  - o_PC_target is held stable until handshake.
  - On req & ack: increment o_Redirects (modulo 2^CNT_W, wraps to 0), then go to DRAIN.
  - Without ack: stay in REDIRECT, no timeout.
- DRAIN:
  - Outputs: o_Flush=1, o_Busy=1, o_Redirect_req=0. This kills the instruction fetched from the old path during the handshake cycle.
  - Always goes to IDLE after one cycle.
- i_Redirect_ack while o_Redirect_req=0 is ignored.
- i_Stall does not affect REDIRECT/DRAIN progress.

## Timing
- Reset (async assert, any state): state=IDLE, o_Redirect_req=0, o_Flush=0, o_Busy=0, o_Misaligned=0, o_PC_target=0, o_Redirects=0. Release is synchronous to i_CLK; the first trigger is sampled on the first edge after deassertion.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Trigger sampled at edge E:
  - o_Redirect_req, o_Flush and o_Busy rise in cycle E+1.
  - If ack is high in cycle E+1, DRAIN is cycle E+2 and IDLE is cycle E+3.
  - A new trigger is first accepted at the edge ending cycle E+3.
- Minimum redirect occupancy is 2 busy cycles; each cycle of ack delay adds one cycle.
- Misaligned pulse appears in cycle E+1; a back-to-back trigger in that cycle is accepted normally.
- Counter updates on the edge that completes the handshake and is visible in DRAIN.

## Test plan
- Aligned taken branch:
  - Stimulus: i_Valid=1, i_DoBranch=1, i_Target=0x0000_0100; ack tied high.
  - Response: req/flush/busy high for 1 cycle with o_PC_target=0x100, then flush/busy for 1 more cycle; o_Redirects 0->1; IDLE after 2 busy cycles.
- Delayed ack:
  - Stimulus: jump to 0x8000_0040; ack asserted 3 cycles after req.
  - Response: req held 4 cycles with target stable; busy 5 cycles total; counter +1 only once.
- Misaligned target:
  - Stimulus: i_DoBranch=1, i_Target=0x0000_0102.
  - Response: o_Misaligned pulse of one cycle; req/flush/busy stay 0; counter unchanged.
- Trigger gating:
  - Stimulus: trigger with i_Stall=1 → no response. Trigger with i_Valid=0 → no response. Second trigger (target 0x200) during REDIRECT → ignored.
  - Response: o_PC_target stays at the first target.
- Reset mid-operation:
  - Stimulus: assert i_RSTn=0 while in REDIRECT.
  - Response: all outputs 0 immediately, with no clock edge required; after release, a fresh branch redirects normally.
- Counter wrap:
  - Stimulus: preload via 65536 redirects, or CNT_W=4 with 16 redirects.
  - Response: o_Redirects wraps to 0 on the final handshake.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// Redirect handshake bundle between the EX-stage redirect controller and its
// surroundings (branch decision in, fetch redirect and pipeline control out).
interface branch_redirect_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic              i_Valid;
    logic              i_DoBranch;
    logic              i_Jump;
    logic [XLEN-1:0]   i_Target;
    logic              i_Stall;
    logic              i_Redirect_ack;
    logic              o_Redirect_req;
    logic [XLEN-1:0]   o_PC_target;
    logic              o_Flush;
    logic              o_Busy;
    logic              o_Misaligned;
    logic [CNT_W-1:0]  o_Redirects;

    modport master (
        output i_Valid, i_DoBranch, i_Jump, i_Target, i_Stall, i_Redirect_ack,
        input  o_Redirect_req, o_PC_target, o_Flush, o_Busy, o_Misaligned, o_Redirects
    );

    modport slave (
        input  i_Valid, i_DoBranch, i_Jump, i_Target, i_Stall, i_Redirect_ack,
        output o_Redirect_req, o_PC_target, o_Flush, o_Busy, o_Misaligned, o_Redirects
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Sequences a taken-branch/jump redirect to fetch: request handshake, IF/ID
// squash over the handshake plus one drain cycle, misalignment flag, counter.
module branch_redirect_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    branch_redirect_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        DRAIN    = 2'b10
    } state_t;

    state_t            state_r;
    logic              req_r;
    logic              flush_r;
    logic              busy_r;
    logic              misaligned_r;
    logic [XLEN-1:0]   pc_target_r;
    logic [CNT_W-1:0]  redirects_r;

    logic              trigger_s;
    logic              aligned_s;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Trigger qualification and target alignment decode.
    always_comb begin
        trigger_s = 1'b0;
        aligned_s = 1'b0;
        if (bus.i_Valid && (bus.i_DoBranch || bus.i_Jump) && !bus.i_Stall) begin
            trigger_s = 1'b1;
        end else begin
            trigger_s = 1'b0;
        end
        aligned_s = is_word_aligned(bus.i_Target);
    end

    // Redirect FSM with registered handshake/pipeline-control outputs.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_r      <= IDLE;
            req_r        <= 1'b0;
            flush_r      <= 1'b0;
            busy_r       <= 1'b0;
            misaligned_r <= 1'b0;
            pc_target_r  <= {XLEN{1'b0}};
            redirects_r  <= {CNT_W{1'b0}};
        end else begin
            misaligned_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (trigger_s && aligned_s) begin
                        pc_target_r <= bus.i_Target;
                        state_r     <= REDIRECT;
                        req_r       <= 1'b1;
                        flush_r     <= 1'b1;
                        busy_r      <= 1'b1;
                    end else if (trigger_s) begin
                        misaligned_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REDIRECT: begin
                    // Ack only counts while the request is actually up.
                    if (req_r && bus.i_Redirect_ack) begin
                        redirects_r <= redirects_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r     <= DRAIN;
                        req_r       <= 1'b0;
                    end else begin
                        state_r <= REDIRECT;
                    end
                end
                DRAIN: begin
                    state_r <= IDLE;
                    flush_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    flush_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Redirect_req = req_r;
    assign bus.o_PC_target    = pc_target_r;
    assign bus.o_Flush        = flush_r;
    assign bus.o_Busy         = busy_r;
    assign bus.o_Misaligned   = misaligned_r;
    assign bus.o_Redirects    = redirects_r;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed-vector bench for branch_redirect_ctrl (counter narrowed to 4 bits
// so the wrap case is reachable in a handful of redirects).
module tb_branch_redirect_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic i_CLK;
    logic i_RSTn;
    int   vec_cnt;
    int   err_cnt;
    int   exp_cnt;

    branch_redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .i_CLK  (i_CLK),
        .i_RSTn (i_RSTn),
        .bus    (bus.slave)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_Valid        = 1'b0;
        bus.i_DoBranch     = 1'b0;
        bus.i_Jump         = 1'b0;
        bus.i_Stall        = 1'b0;
        bus.i_Redirect_ack = 1'b0;
    endtask

    task automatic check_ctl(input string tag, input logic req, input logic flush, input logic busy);
        check_eq({tag, "_req"},   {31'd0, bus.o_Redirect_req}, {31'd0, req});
        check_eq({tag, "_flush"}, {31'd0, bus.o_Flush},        {31'd0, flush});
        check_eq({tag, "_busy"},  {31'd0, bus.o_Busy},         {31'd0, busy});
    endtask

    // One complete redirect with ack tied high; exp_cnt tracks the wrapping count.
    task automatic do_redirect(input logic [31:0] tgt);
        bus.i_Valid        = 1'b1;
        bus.i_DoBranch     = 1'b1;
        bus.i_Target       = tgt;
        bus.i_Redirect_ack = 1'b1;
        tick();
        idle_inputs();
        bus.i_Redirect_ack = 1'b1;
        tick();
        exp_cnt = (exp_cnt + 1) % 16;
        tick();
        bus.i_Redirect_ack = 1'b0;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        exp_cnt = 0;
        idle_inputs();
        bus.i_Target = 32'h0;
        i_RSTn = 1'b0;
        #23;
        check_ctl("rst", 1'b0, 1'b0, 1'b0);
        check_eq("rst_pc",  bus.o_PC_target, 32'h0);
        check_eq("rst_cnt", {28'd0, bus.o_Redirects}, 32'd0);
        check_eq("rst_mis", {31'd0, bus.o_Misaligned}, 32'd0);
        i_RSTn = 1'b1;
        tick();

        // Aligned taken branch, ack tied high.
        bus.i_Valid = 1'b1; bus.i_DoBranch = 1'b1; bus.i_Target = 32'h0000_0100;
        bus.i_Redirect_ack = 1'b1;
        tick();
        idle_inputs(); bus.i_Redirect_ack = 1'b1;
        check_ctl("br_e1", 1'b1, 1'b1, 1'b1);
        check_eq("br_e1_pc",  bus.o_PC_target, 32'h0000_0100);
        check_eq("br_e1_cnt", {28'd0, bus.o_Redirects}, 32'd0);
        tick();
        check_ctl("br_drain", 1'b0, 1'b1, 1'b1);
        check_eq("br_drain_cnt", {28'd0, bus.o_Redirects}, 32'd1);
        tick();
        check_ctl("br_idle", 1'b0, 1'b0, 1'b0);
        bus.i_Redirect_ack = 1'b0;

        // Jump with ack three cycles late; a 0x200 trigger during REDIRECT is ignored.
        bus.i_Valid = 1'b1; bus.i_Jump = 1'b1; bus.i_Target = 32'h8000_0040;
        tick();
        bus.i_Jump = 1'b0; bus.i_DoBranch = 1'b1; bus.i_Target = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            check_ctl($sformatf("jmp_wait%0d", i), 1'b1, 1'b1, 1'b1);
            check_eq($sformatf("jmp_wait%0d_pc", i), bus.o_PC_target, 32'h8000_0040);
            tick();
        end
        idle_inputs();
        bus.i_Redirect_ack = 1'b1;
        check_ctl("jmp_ack", 1'b1, 1'b1, 1'b1);
        check_eq("jmp_ack_cnt", {28'd0, bus.o_Redirects}, 32'd1);
        tick();
        bus.i_Redirect_ack = 1'b0;
        check_ctl("jmp_drain", 1'b0, 1'b1, 1'b1);
        check_eq("jmp_drain_cnt", {28'd0, bus.o_Redirects}, 32'd2);
        tick();
        check_ctl("jmp_idle", 1'b0, 1'b0, 1'b0);
        check_eq("jmp_idle_pc",  bus.o_PC_target, 32'h8000_0040);
        check_eq("jmp_idle_cnt", {28'd0, bus.o_Redirects}, 32'd2);

        // Misaligned target, then a back-to-back aligned trigger during the pulse.
        bus.i_Valid = 1'b1; bus.i_DoBranch = 1'b1; bus.i_Target = 32'h0000_0102;
        tick();
        check_eq("mis_pulse", {31'd0, bus.o_Misaligned}, 32'd1);
        check_ctl("mis_ctl", 1'b0, 1'b0, 1'b0);
        check_eq("mis_pc", bus.o_PC_target, 32'h8000_0040);
        bus.i_Target = 32'h0000_0300;
        tick();
        idle_inputs();
        check_eq("mis_clear", {31'd0, bus.o_Misaligned}, 32'd0);
        check_ctl("b2b_req", 1'b1, 1'b1, 1'b1);
        check_eq("b2b_pc", bus.o_PC_target, 32'h0000_0300);
        check_eq("mis_cnt", {28'd0, bus.o_Redirects}, 32'd2);
        bus.i_Redirect_ack = 1'b1;
        tick();
        bus.i_Redirect_ack = 1'b0;
        tick();
        check_eq("b2b_cnt", {28'd0, bus.o_Redirects}, 32'd3);

        // Trigger gating: stalled, invalid, and a stray ack while idle.
        bus.i_Valid = 1'b1; bus.i_DoBranch = 1'b1; bus.i_Stall = 1'b1; bus.i_Target = 32'h0000_0400;
        tick();
        check_ctl("stall", 1'b0, 1'b0, 1'b0);
        bus.i_Valid = 1'b0; bus.i_Stall = 1'b0;
        bus.i_Redirect_ack = 1'b1;
        tick();
        check_ctl("novalid", 1'b0, 1'b0, 1'b0);
        check_eq("gate_pc",  bus.o_PC_target, 32'h0000_0300);
        check_eq("gate_cnt", {28'd0, bus.o_Redirects}, 32'd3);
        idle_inputs();

        // Asynchronous reset while in REDIRECT.
        bus.i_Valid = 1'b1; bus.i_DoBranch = 1'b1; bus.i_Target = 32'h0000_0500;
        tick();
        idle_inputs();
        check_ctl("pre_rst", 1'b1, 1'b1, 1'b1);
        #2;
        i_RSTn = 1'b0;
        #1;
        check_ctl("async_rst", 1'b0, 1'b0, 1'b0);
        check_eq("async_rst_pc",  bus.o_PC_target, 32'h0);
        check_eq("async_rst_cnt", {28'd0, bus.o_Redirects}, 32'd0);
        #10;
        i_RSTn = 1'b1;
        tick();
        exp_cnt = 0;
        bus.i_Valid = 1'b1; bus.i_DoBranch = 1'b1; bus.i_Target = 32'h0000_0600;
        bus.i_Redirect_ack = 1'b1;
        tick();
        idle_inputs(); bus.i_Redirect_ack = 1'b1;
        check_ctl("post_rst", 1'b1, 1'b1, 1'b1);
        check_eq("post_rst_pc", bus.o_PC_target, 32'h0000_0600);
        tick();
        tick();
        bus.i_Redirect_ack = 1'b0;
        exp_cnt = 1;
        check_eq("post_rst_cnt", {28'd0, bus.o_Redirects}, 32'd1);

        // Counter wrap: 14 more to reach 15, then the 16th wraps to 0.
        for (int i = 0; i < 14; i++) begin
            do_redirect(32'h0000_1000 + 32'(i) * 32'd4);
        end
        check_eq("cnt_15", {28'd0, bus.o_Redirects}, 32'd15);
        check_eq("cnt_15_model", {28'd0, bus.o_Redirects}, 32'(exp_cnt));
        do_redirect(32'h0000_2000);
        check_eq("cnt_wrap", {28'd0, bus.o_Redirects}, 32'd0);
        check_eq("cnt_wrap_pc", bus.o_PC_target, 32'h0000_2000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
